// File: rtl/mem_bus_arbiter_pkg.sv
// rtl/mem_bus_arbiter_pkg.sv - shared types and constants for the memory bus arbiter
//
// Purpose:
//   Holds the arbiter FSM state encoding, the bus owner encoding, the
//   one-hot grant codes produced by rr_arbiter2, and the downstream
//   response code that means "no error".
// Ports: none (package).

package mem_bus_arbiter_pkg;

  typedef enum logic [2:0] {
    ARB_IDLE    = 3'd0,
    ARB_RD_ADDR = 3'd1,
    ARB_RD_DATA = 3'd2,
    ARB_WR_REQ  = 3'd3,
    ARB_WR_RESP = 3'd4
  } arb_state_t;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_t;

  // One-hot grant vector: bit 0 is the IFU, bit 1 is the LSU.
  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_IFU  = 2'b01;
  localparam logic [1:0] GNT_LSU  = 2'b10;

  // Downstream rresp/bresp value for a successful transfer; any other
  // value is reported upstream as an error.
  localparam logic [1:0] RESP_OKAY = 2'b00;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr.sv
// rtl/mem_bus_arbiter_rr.sv - two-way round-robin grant logic with response masking
//
// Purpose:
//   Chooses between the IFU and LSU requests. A requester whose response
//   pulse is high this cycle is masked so a request that has not dropped
//   yet is not granted twice. On a tie the requester that was not granted
//   last wins.
// Ports:
//   ifu_req, lsu_req   raw requests from the two bus ports
//   ifu_mask, lsu_mask response pulse currently high for that requester
//   last_gnt           owner of the most recent grant
//   gnt                one-hot grant (GNT_IFU / GNT_LSU / GNT_NONE)

module rr_arbiter2
  import mem_bus_arbiter_pkg::*;
(
  input  logic       ifu_req,
  input  logic       lsu_req,
  input  logic       ifu_mask,
  input  logic       lsu_mask,
  input  owner_t     last_gnt,
  output logic [1:0] gnt
);

  logic ifu_eff;
  logic lsu_eff;

  always_comb begin
    ifu_eff = ifu_req & ~ifu_mask;
    lsu_eff = lsu_req & ~lsu_mask;
    gnt     = GNT_NONE;
    if (ifu_eff && lsu_eff) begin
      gnt = (last_gnt == OWN_IFU) ? GNT_LSU : GNT_IFU;
    end else if (ifu_eff) begin
      gnt = GNT_IFU;
    end else if (lsu_eff) begin
      gnt = GNT_LSU;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - shares one memory bus between the IFU and the LSU
//
// Purpose:
//   Grants one transaction at a time to either the instruction fetch unit
//   (reads only) or the load/store unit (reads and writes), registers the
//   winner's address/data/strobe, runs the downstream AR/R or W/B exchange
//   and returns a one-cycle response pulse to the owner. Transactions that
//   stay outstanding for TIMEOUT cycles are aborted with an error.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   ifu_araddr_i/ifu_arvalid_i    IFU read request
//   ifu_rdata_o/rvalid_o/err_o    IFU read response (pulse qualifies data/err)
//   lsu_addr_i/arvalid_i/wvalid_i LSU request (shared address for read/write)
//   lsu_wdata_i/lsu_wstrb_i       LSU write data and byte strobes
//   lsu_rdata_o/rvalid_o/bvalid_o LSU read and write responses
//   lsu_err_o                     LSU error, qualified by either pulse
//   m_araddr_o/m_arvalid_o/m_arready_i         downstream read address
//   m_rdata_i/m_rresp_i/m_rvalid_i             downstream read data
//   m_awaddr_o/m_wdata_o/m_wstrb_o/m_wvalid_o/m_wready_i  write beat
//   m_bresp_i/m_bvalid_i                       downstream write response

module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   ifu_araddr_i,
  input  logic                ifu_arvalid_i,
  output logic [DATA_W-1:0]   ifu_rdata_o,
  output logic                ifu_rvalid_o,
  output logic                ifu_err_o,
  input  logic [ADDR_W-1:0]   lsu_addr_i,
  input  logic                lsu_arvalid_i,
  input  logic                lsu_wvalid_i,
  input  logic [DATA_W-1:0]   lsu_wdata_i,
  input  logic [DATA_W/8-1:0] lsu_wstrb_i,
  output logic [DATA_W-1:0]   lsu_rdata_o,
  output logic                lsu_rvalid_o,
  output logic                lsu_bvalid_o,
  output logic                lsu_err_o,
  output logic [ADDR_W-1:0]   m_araddr_o,
  output logic                m_arvalid_o,
  input  logic                m_arready_i,
  input  logic [DATA_W-1:0]   m_rdata_i,
  input  logic [1:0]          m_rresp_i,
  input  logic                m_rvalid_i,
  output logic [ADDR_W-1:0]   m_awaddr_o,
  output logic [DATA_W-1:0]   m_wdata_o,
  output logic [DATA_W/8-1:0] m_wstrb_o,
  output logic                m_wvalid_o,
  input  logic                m_wready_i,
  input  logic [1:0]          m_bresp_i,
  input  logic                m_bvalid_i
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_t state;
  arb_state_t state_nxt;
  owner_t     owner;
  owner_t     last_gnt;

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic [CNT_W-1:0]  cnt;

  logic [1:0]        gnt;
  logic              timeout_hit;
  logic              rd_rsp;
  logic              wr_rsp;
  logic              rsp_err;
  logic [DATA_W-1:0] rsp_rdata;

  // Masking uses the registered pulses: the owner is back in IDLE during its
  // pulse cycle but has not yet seen the response to drop its request.
  rr_arbiter2 u_rr (
    .ifu_req  (ifu_arvalid_i),
    .lsu_req  (lsu_arvalid_i | lsu_wvalid_i),
    .ifu_mask (ifu_rvalid_o),
    .lsu_mask (lsu_rvalid_o | lsu_bvalid_o),
    .last_gnt (last_gnt),
    .gnt      (gnt)
  );

  assign m_araddr_o = addr_q;
  assign m_awaddr_o = addr_q;
  assign m_wdata_o  = wdata_q;
  assign m_wstrb_o  = wstrb_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    m_arvalid_o = 1'b0;
    m_wvalid_o  = 1'b0;
    rd_rsp      = 1'b0;
    wr_rsp      = 1'b0;
    rsp_err     = 1'b0;
    rsp_rdata   = '0;
    timeout_hit = (state != ARB_IDLE) && (cnt == CNT_LAST);

    unique case (state)
      ARB_IDLE: begin
        // A write beats a read when the LSU raises both.
        if (gnt == GNT_LSU) begin
          state_nxt = lsu_wvalid_i ? ARB_WR_REQ : ARB_RD_ADDR;
        end else if (gnt == GNT_IFU) begin
          state_nxt = ARB_RD_ADDR;
        end
      end

      ARB_RD_ADDR: begin
        m_arvalid_o = 1'b1;
        if (timeout_hit) begin
          rd_rsp    = 1'b1;
          rsp_err   = 1'b1;
          state_nxt = ARB_IDLE;
        end else if (m_arready_i) begin
          state_nxt = ARB_RD_DATA;
        end
      end

      ARB_RD_DATA: begin
        // A response arriving on the timeout cycle still completes normally.
        if (m_rvalid_i) begin
          rd_rsp    = 1'b1;
          rsp_err   = resp_is_err(m_rresp_i);
          rsp_rdata = m_rdata_i;
          state_nxt = ARB_IDLE;
        end else if (timeout_hit) begin
          rd_rsp    = 1'b1;
          rsp_err   = 1'b1;
          state_nxt = ARB_IDLE;
        end
      end

      ARB_WR_REQ: begin
        m_wvalid_o = 1'b1;
        if (timeout_hit) begin
          wr_rsp    = 1'b1;
          rsp_err   = 1'b1;
          state_nxt = ARB_IDLE;
        end else if (m_wready_i) begin
          state_nxt = ARB_WR_RESP;
        end
      end

      ARB_WR_RESP: begin
        if (m_bvalid_i) begin
          wr_rsp    = 1'b1;
          rsp_err   = resp_is_err(m_bresp_i);
          state_nxt = ARB_IDLE;
        end else if (timeout_hit) begin
          wr_rsp    = 1'b1;
          rsp_err   = 1'b1;
          state_nxt = ARB_IDLE;
        end
      end

      default: begin
        state_nxt = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner        <= OWN_IFU;
      last_gnt     <= OWN_IFU;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      cnt          <= '0;
      ifu_rdata_o  <= '0;
      ifu_rvalid_o <= 1'b0;
      ifu_err_o    <= 1'b0;
      lsu_rdata_o  <= '0;
      lsu_rvalid_o <= 1'b0;
      lsu_bvalid_o <= 1'b0;
      lsu_err_o    <= 1'b0;
    end else begin
      ifu_rvalid_o <= 1'b0;
      ifu_err_o    <= 1'b0;
      lsu_rvalid_o <= 1'b0;
      lsu_bvalid_o <= 1'b0;
      lsu_err_o    <= 1'b0;

      if (state == ARB_IDLE) begin
        if (gnt == GNT_LSU) begin
          owner    <= OWN_LSU;
          last_gnt <= OWN_LSU;
          addr_q   <= lsu_addr_i;
          wdata_q  <= lsu_wvalid_i ? lsu_wdata_i : '0;
          wstrb_q  <= lsu_wvalid_i ? lsu_wstrb_i : '0;
          cnt      <= '0;
        end else if (gnt == GNT_IFU) begin
          owner    <= OWN_IFU;
          last_gnt <= OWN_IFU;
          addr_q   <= ifu_araddr_i;
          wdata_q  <= '0;
          wstrb_q  <= '0;
          cnt      <= '0;
        end
      end else begin
        // Cannot wrap: reaching CNT_LAST always forces a return to IDLE.
        cnt <= cnt + CNT_W'(1);
      end

      // Only the owner's rdata is updated; the other side keeps its value.
      if (rd_rsp) begin
        if (owner == OWN_IFU) begin
          ifu_rvalid_o <= 1'b1;
          ifu_err_o    <= rsp_err;
          ifu_rdata_o  <= rsp_rdata;
        end else begin
          lsu_rvalid_o <= 1'b1;
          lsu_err_o    <= rsp_err;
          lsu_rdata_o  <= rsp_rdata;
        end
      end

      if (wr_rsp) begin
        lsu_bvalid_o <= 1'b1;
        lsu_err_o    <= rsp_err;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed self-checking bench for mem_bus_arbiter

module tb_mem_bus_arbiter;

  logic        clk;
  logic        rst;
  logic [31:0] ifu_araddr_i;
  logic        ifu_arvalid_i;
  logic [31:0] ifu_rdata_o;
  logic        ifu_rvalid_o;
  logic        ifu_err_o;
  logic [31:0] lsu_addr_i;
  logic        lsu_arvalid_i;
  logic        lsu_wvalid_i;
  logic [31:0] lsu_wdata_i;
  logic [3:0]  lsu_wstrb_i;
  logic [31:0] lsu_rdata_o;
  logic        lsu_rvalid_o;
  logic        lsu_bvalid_o;
  logic        lsu_err_o;
  logic [31:0] m_araddr_o;
  logic        m_arvalid_o;
  logic        m_arready_i;
  logic [31:0] m_rdata_i;
  logic [1:0]  m_rresp_i;
  logic        m_rvalid_i;
  logic [31:0] m_awaddr_o;
  logic [31:0] m_wdata_o;
  logic [3:0]  m_wstrb_o;
  logic        m_wvalid_o;
  logic        m_wready_i;
  logic [1:0]  m_bresp_i;
  logic        m_bvalid_i;

  int vectors;
  int miscompares;

  mem_bus_arbiter #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ifu_araddr_i  (ifu_araddr_i),
    .ifu_arvalid_i (ifu_arvalid_i),
    .ifu_rdata_o   (ifu_rdata_o),
    .ifu_rvalid_o  (ifu_rvalid_o),
    .ifu_err_o     (ifu_err_o),
    .lsu_addr_i    (lsu_addr_i),
    .lsu_arvalid_i (lsu_arvalid_i),
    .lsu_wvalid_i  (lsu_wvalid_i),
    .lsu_wdata_i   (lsu_wdata_i),
    .lsu_wstrb_i   (lsu_wstrb_i),
    .lsu_rdata_o   (lsu_rdata_o),
    .lsu_rvalid_o  (lsu_rvalid_o),
    .lsu_bvalid_o  (lsu_bvalid_o),
    .lsu_err_o     (lsu_err_o),
    .m_araddr_o    (m_araddr_o),
    .m_arvalid_o   (m_arvalid_o),
    .m_arready_i   (m_arready_i),
    .m_rdata_i     (m_rdata_i),
    .m_rresp_i     (m_rresp_i),
    .m_rvalid_i    (m_rvalid_i),
    .m_awaddr_o    (m_awaddr_o),
    .m_wdata_o     (m_wdata_o),
    .m_wstrb_o     (m_wstrb_o),
    .m_wvalid_o    (m_wvalid_o),
    .m_wready_i    (m_wready_i),
    .m_bresp_i     (m_bresp_i),
    .m_bvalid_i    (m_bvalid_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk1({tag, "_ifu_rvalid"}, ifu_rvalid_o, 1'b0);
    chk1({tag, "_ifu_err"}, ifu_err_o, 1'b0);
    chk32({tag, "_ifu_rdata"}, ifu_rdata_o, 32'h0);
    chk1({tag, "_lsu_rvalid"}, lsu_rvalid_o, 1'b0);
    chk1({tag, "_lsu_bvalid"}, lsu_bvalid_o, 1'b0);
    chk1({tag, "_lsu_err"}, lsu_err_o, 1'b0);
    chk32({tag, "_lsu_rdata"}, lsu_rdata_o, 32'h0);
    chk1({tag, "_arvalid"}, m_arvalid_o, 1'b0);
    chk1({tag, "_wvalid"}, m_wvalid_o, 1'b0);
    chk32({tag, "_araddr"}, m_araddr_o, 32'h0);
    chk32({tag, "_awaddr"}, m_awaddr_o, 32'h0);
    chk32({tag, "_wdata"}, m_wdata_o, 32'h0);
    chk32({tag, "_wstrb"}, 32'(m_wstrb_o), 32'h0);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    ifu_araddr_i = '0; ifu_arvalid_i = 1'b0;
    lsu_addr_i = '0; lsu_arvalid_i = 1'b0; lsu_wvalid_i = 1'b0;
    lsu_wdata_i = '0; lsu_wstrb_i = '0;
    m_arready_i = 1'b0; m_rdata_i = '0; m_rresp_i = '0; m_rvalid_i = 1'b0;
    m_wready_i = 1'b0; m_bresp_i = '0; m_bvalid_i = 1'b0;

    // Reset state
    cyc();
    cyc();
    chk_all_zero("reset");
    rst = 1'b0;

    // IFU read, minimum latency; request held through its pulse (masking)
    ifu_araddr_i = 32'h8000_0000; ifu_arvalid_i = 1'b1; m_arready_i = 1'b1;
    cyc();
    chk1("t1_arvalid", m_arvalid_o, 1'b1);
    chk32("t1_araddr", m_araddr_o, 32'h8000_0000);
    cyc();
    chk1("t1_arvalid_drop", m_arvalid_o, 1'b0);
    chk1("t1_no_early_rvalid", ifu_rvalid_o, 1'b0);
    m_rvalid_i = 1'b1; m_rdata_i = 32'h0000_0413; m_rresp_i = 2'd0;
    cyc();
    chk1("t1_rvalid", ifu_rvalid_o, 1'b1);
    chk32("t1_rdata", ifu_rdata_o, 32'h0000_0413);
    chk1("t1_err", ifu_err_o, 1'b0);
    m_rvalid_i = 1'b0; m_rdata_i = '0;
    cyc();
    ifu_arvalid_i = 1'b0;
    chk1("t1_rvalid_one_cycle", ifu_rvalid_o, 1'b0);
    chk1("t1_masked_no_regrant", m_arvalid_o, 1'b0);

    // Tie after reset: LSU first, then IFU right after the LSU pulse
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk32("rst2_ifu_rdata", ifu_rdata_o, 32'h0);
    ifu_araddr_i = 32'h0000_0100; ifu_arvalid_i = 1'b1;
    lsu_addr_i = 32'h0000_0200; lsu_arvalid_i = 1'b1;
    cyc();
    chk32("t2_first_lsu", m_araddr_o, 32'h0000_0200);
    cyc();
    m_rvalid_i = 1'b1; m_rdata_i = 32'h0000_0022;
    cyc();
    chk1("t2_lsu_rvalid", lsu_rvalid_o, 1'b1);
    chk32("t2_lsu_rdata", lsu_rdata_o, 32'h0000_0022);
    chk1("t2_ifu_quiet", ifu_rvalid_o, 1'b0);
    m_rvalid_i = 1'b0; lsu_arvalid_i = 1'b0;
    cyc();
    chk1("t2_ifu_granted", m_arvalid_o, 1'b1);
    chk32("t2_ifu_addr", m_araddr_o, 32'h0000_0100);
    cyc();
    m_rvalid_i = 1'b1; m_rdata_i = 32'h0000_0011;
    cyc();
    chk1("t2_ifu_rvalid", ifu_rvalid_o, 1'b1);
    chk32("t2_ifu_rdata", ifu_rdata_o, 32'h0000_0011);
    chk32("t2_lsu_rdata_held", lsu_rdata_o, 32'h0000_0022);
    ifu_arvalid_i = 1'b0; m_rvalid_i = 1'b0;
    cyc();
    // Second tie, last grant IFU -> LSU
    ifu_arvalid_i = 1'b1; lsu_arvalid_i = 1'b1;
    cyc();
    chk32("t2_tie2_lsu", m_araddr_o, 32'h0000_0200);
    cyc();
    m_rvalid_i = 1'b1; m_rdata_i = 32'h0000_0033;
    cyc();
    chk1("t2_tie2_lsu_rvalid", lsu_rvalid_o, 1'b1);
    chk32("t2_tie2_lsu_rdata", lsu_rdata_o, 32'h0000_0033);
    ifu_arvalid_i = 1'b0; lsu_arvalid_i = 1'b0; m_rvalid_i = 1'b0;
    cyc();
    // Third tie, last grant LSU -> IFU
    ifu_arvalid_i = 1'b1; lsu_arvalid_i = 1'b1;
    cyc();
    chk32("t2_tie3_ifu", m_araddr_o, 32'h0000_0100);
    cyc();
    ifu_arvalid_i = 1'b0; lsu_arvalid_i = 1'b0;
    m_rvalid_i = 1'b1; m_rdata_i = 32'h0000_0044;
    cyc();
    chk1("t2_tie3_ifu_rvalid", ifu_rvalid_o, 1'b1);
    chk32("t2_tie3_ifu_rdata", ifu_rdata_o, 32'h0000_0044);
    chk1("t2_tie3_lsu_quiet", lsu_rvalid_o, 1'b0);
    m_rvalid_i = 1'b0;
    cyc();

    // LSU write (with arvalid also raised: write wins), wready after 3 cycles
    lsu_addr_i = 32'hA000_03F8; lsu_wdata_i = 32'h0000_0041; lsu_wstrb_i = 4'h1;
    lsu_wvalid_i = 1'b1; lsu_arvalid_i = 1'b1; m_wready_i = 1'b0;
    cyc();
    lsu_wvalid_i = 1'b0; lsu_arvalid_i = 1'b0;
    lsu_addr_i = 32'h0000_DEAD; lsu_wdata_i = 32'hFFFF_FFFF; lsu_wstrb_i = 4'hF;
    for (int i = 0; i < 4; i++) begin
      chk1("t3_wvalid", m_wvalid_o, 1'b1);
      chk1("t3_no_arvalid", m_arvalid_o, 1'b0);
      chk32("t3_awaddr", m_awaddr_o, 32'hA000_03F8);
      chk32("t3_wdata", m_wdata_o, 32'h0000_0041);
      chk32("t3_wstrb", 32'(m_wstrb_o), 32'h1);
      if (i == 3) m_wready_i = 1'b1;
      cyc();
    end
    chk1("t3_wvalid_drop", m_wvalid_o, 1'b0);
    chk1("t3_no_early_bvalid", lsu_bvalid_o, 1'b0);
    m_wready_i = 1'b0; m_bvalid_i = 1'b1; m_bresp_i = 2'd0;
    cyc();
    chk1("t3_bvalid", lsu_bvalid_o, 1'b1);
    chk1("t3_err", lsu_err_o, 1'b0);
    chk1("t3_no_rvalid", lsu_rvalid_o, 1'b0);
    m_bvalid_i = 1'b0;
    cyc();
    chk1("t3_bvalid_one_cycle", lsu_bvalid_o, 1'b0);

    // LSU read with error response
    lsu_addr_i = 32'h0000_0300; lsu_arvalid_i = 1'b1;
    cyc();
    lsu_arvalid_i = 1'b0;
    chk32("t4_araddr", m_araddr_o, 32'h0000_0300);
    chk1("t4_ifu_quiet_a", ifu_rvalid_o, 1'b0);
    cyc();
    chk1("t4_ifu_quiet_b", ifu_rvalid_o, 1'b0);
    m_rvalid_i = 1'b1; m_rresp_i = 2'd2; m_rdata_i = 32'h0000_0055;
    cyc();
    chk1("t4_lsu_rvalid", lsu_rvalid_o, 1'b1);
    chk1("t4_lsu_err", lsu_err_o, 1'b1);
    chk1("t4_ifu_quiet_c", ifu_rvalid_o, 1'b0);
    m_rvalid_i = 1'b0; m_rresp_i = 2'd0; m_rdata_i = '0;
    cyc();
    chk1("t4_ifu_quiet_d", ifu_rvalid_o, 1'b0);

    // Timeout: arready never asserted, TIMEOUT=8
    m_arready_i = 1'b0;
    ifu_araddr_i = 32'h0000_0400; ifu_arvalid_i = 1'b1;
    cyc();
    ifu_arvalid_i = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      chk1("t5_arvalid_held", m_arvalid_o, 1'b1);
      chk1("t5_no_rvalid", ifu_rvalid_o, 1'b0);
      cyc();
    end
    chk1("t5_arvalid_drop", m_arvalid_o, 1'b0);
    chk1("t5_rvalid", ifu_rvalid_o, 1'b1);
    chk1("t5_err", ifu_err_o, 1'b1);
    chk32("t5_rdata_zero", ifu_rdata_o, 32'h0);
    cyc();
    chk1("t5_rvalid_one_cycle", ifu_rvalid_o, 1'b0);

    // Reset while in RD_DATA, then a late downstream response
    m_arready_i = 1'b1;
    lsu_addr_i = 32'h0000_0500; lsu_arvalid_i = 1'b1;
    cyc();
    lsu_arvalid_i = 1'b0;
    chk1("t6_arvalid", m_arvalid_o, 1'b1);
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk_all_zero("t6_after_rst");
    m_rvalid_i = 1'b1; m_rdata_i = 32'h0000_0099;
    cyc();
    chk1("t6_late_lsu_rvalid", lsu_rvalid_o, 1'b0);
    chk1("t6_late_ifu_rvalid", ifu_rvalid_o, 1'b0);
    chk32("t6_late_lsu_rdata", lsu_rdata_o, 32'h0);
    chk1("t6_idle_arvalid", m_arvalid_o, 1'b0);
    m_rvalid_i = 1'b0;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Shares the single memory bus between the instruction fetch unit (read-only) and the load/store unit (read and write). Grants one transaction at a time and registers the winner's address, data and strobe. Drives the downstream AR/R/W/B channels and returns a one-cycle response pulse to the owner. Sits between the IFU/LSU bus ports and the memory/peripheral crossbar.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; strobe width is DATA_W/8
TIMEOUT, 256, cycles a granted transaction may remain outstanding before it is aborted with an error

Ports:
clk  in  1  clock
rst  in  1  reset
ifu_araddr_i  in  ADDR_W  IFU read address
ifu_arvalid_i  in  1  IFU read request, held until ifu_rvalid_o
ifu_rdata_o  out  DATA_W  IFU read data
ifu_rvalid_o  out  1  one-cycle IFU response pulse
ifu_err_o  out  1  IFU error, qualified by ifu_rvalid_o
lsu_addr_i  in  ADDR_W  LSU address, used for both read and write
lsu_arvalid_i  in  1  LSU read request
lsu_wvalid_i  in  1  LSU write request
lsu_wdata_i  in  DATA_W  LSU write data
lsu_wstrb_i  in  DATA_W/8  LSU byte strobes
lsu_rdata_o  out  DATA_W  LSU read data
lsu_rvalid_o  out  1  one-cycle LSU read response pulse
lsu_bvalid_o  out  1  one-cycle LSU write response pulse
lsu_err_o  out  1  LSU error, qualified by lsu_rvalid_o or lsu_bvalid_o
m_araddr_o  out  ADDR_W  downstream read address
m_arvalid_o  out  1  downstream read address valid
m_arready_i  in  1  downstream read address accepted
m_rdata_i  in  DATA_W  downstream read data
m_rresp_i  in  2  downstream read response; nonzero means error
m_rvalid_i  in  1  downstream read data valid; no backpressure
m_awaddr_o  out  ADDR_W  downstream write address
m_wdata_o  out  DATA_W  downstream write data
m_wstrb_o  out  DATA_W/8  downstream write strobes
m_wvalid_o  out  1  downstream write address+data valid as one beat
m_wready_i  in  1  downstream write accepted
m_bresp_i  in  2  downstream write response; nonzero means error
m_bvalid_i  in  1  downstream write response valid; no backpressure

Behaviour:
- One clock. Reset is synchronous and active-high. Clock and reset ports are named clk and rst.
- Reset, including mid-transaction: state IDLE, all valid/pulse/err outputs 0, data/address outputs 0, timeout counter 0, last_gnt=IFU. Any outstanding downstream response is ignored.
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP.
- Requests in IDLE: ifu_req=ifu_arvalid_i; lsu_req=lsu_arvalid_i|lsu_wvalid_i.
  - Only one request: that requester wins.
  - Both: the requester other than last_gnt wins. With last_gnt reset to IFU, LSU wins the first tie.
  - LSU with both arvalid and wvalid: the write wins.
- Masking: a requester whose rvalid/bvalid pulse is high in the current cycle is masked from arbitration that cycle. This prevents a double grant on a request that has not yet dropped.
- Grant cycle: latch owner, address, wdata and wstrb; update last_gnt; clear the timeout counter. Next state is RD_ADDR or WR_REQ. Upstream signals need be stable only in the grant cycle.
- RD_ADDR: m_arvalid_o=1 with the latched address. On m_arready_i, go to RD_DATA; m_arvalid_o drops the following cycle.
- RD_DATA: on m_rvalid_i, capture m_rdata_i. Owner rvalid_o=1 for exactly one cycle (the next cycle), err=(m_rresp_i!=0). Go to IDLE.
- WR_REQ: m_wvalid_o=1 with awaddr, wdata and wstrb held. On m_wready_i, go to WR_RESP.
- WR_RESP: on m_bvalid_i, pulse lsu_bvalid_o for one cycle, err=(m_bresp_i!=0). Go to IDLE.
- Minimum read latency (arready same cycle, rvalid next cycle): request at cycle 0, m_arvalid_o at cycle 1, m_rvalid_i at cycle 2, rvalid_o at cycle 3.
- Timeout: the counter increments every non-IDLE cycle. When it reaches TIMEOUT-1 with no completion:
  - drop m_*valid;
  - pulse the owner's response with err=1 and rdata=0;
  - go to IDLE.
  - A completion in the same cycle as the timeout takes priority over the timeout.
- The non-owner's rdata output holds its previous value. Response data is meaningful only while the pulse is high.
- Downstream valid stays stable until accepted; address and data never change while valid is high.

Decomposition:
- Shared package: state encoding constants (ARB_IDLE, ARB_RD_ADDR, ARB_RD_DATA, ARB_WR_REQ, ARB_WR_RESP), owner encoding (OWN_IFU=0, OWN_LSU=1) and the response-error code constant.
- One sub-module, rr_arbiter2: two requests plus last_gnt in, one-hot grant out, masking applied.

Test Plan:
- IFU read 0x8000_0000; arready same cycle, rvalid 1 cycle later with rdata 0x0000_0413 -> ifu_rvalid_o one cycle at cycle 3, ifu_rdata_o=0x413, ifu_err_o=0.
- IFU read and LSU read requested in the same cycle after reset -> LSU granted first. IFU granted right after the LSU response. A second tie then goes to whichever requester was not granted last.
- LSU write addr 0xA000_03F8, wdata 0x41, wstrb 0x1; wready delayed 3 cycles; bresp=0 -> m_wvalid_o held 4 cycles with stable fields, then one lsu_bvalid_o pulse.
- LSU read with m_rresp_i=2 -> lsu_rvalid_o with lsu_err_o=1. ifu_rvalid_o stays 0 throughout.
- TIMEOUT=8, IFU read with arready never asserted -> m_arvalid_o drops; ifu_rvalid_o=1, ifu_err_o=1, rdata=0, 8 cycles after grant.
- rst asserted while in RD_DATA, then late m_rvalid_i -> no upstream pulse, state IDLE, all outputs 0 the cycle after rst.
